mchester_encode: RTL and testbench

Manchester transmitter for the 45-bit tag frame, producing the half-bit symbol stream that the FSK stage consumes. It loads a frame word on a start request and serialises it MSB-first (bit 44 down to bit 0), one bit at a time. Each bit is sent as two half-bit symbols: the true value, then its complement. A toggle strobe marks every half-bit boundary, so a half-bit-sampling Manchester receiver, which keeps the first half of each bit, recovers the word unchanged. The block sits between the frame-assembly logic and the FSK modulator, all clocked from `sqwv`.

---
 rtl/mchester_encode.sv | 138 +++++++++++++
 tb/tb_mchester_encode.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mchester_encode.sv
`default_nettype none
// ============================================================================
// Module   : mchester_encode
// Brief    : Manchester transmitter for the tag frame. Each bit is sent MSB
//            first as its true value then its complement, with a toggle
//            strobe at every half-bit boundary. Clocked from sqwv.
//            Optional build macro MCHESTER_REPEAT_EN enables gapless frame
//            repetition while start is held high.
// Revision : 1.0 - initial release
// ============================================================================
module mchester_encode #(
    parameter int HALF_BIT_CYCLES = 32,
    parameter int FRAME_BITS      = 45
) (
    input  logic                  sqwv,
    input  logic                  manual_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic                  fsk_in,
    output logic                  fsk_in_trigger
);

    localparam int c_HCW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam int c_BCW = $clog2(FRAME_BITS + 1);

    localparam logic [c_HCW-1:0] c_HALF_LAST = c_HCW'(HALF_BIT_CYCLES - 1);
    localparam logic [c_BCW-1:0] c_BIT_LAST  = c_BCW'(FRAME_BITS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_HALF1 = 2'd1;
    localparam logic [1:0] c_HALF2 = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [c_BCW-1:0]      r_bit_cnt;
    logic [c_HCW-1:0]      r_half_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fsk;
    logic                  r_trig;
`ifdef MCHESTER_REPEAT_EN
    logic [FRAME_BITS-1:0] r_copy;
`endif

    logic w_half_end;
    assign w_half_end = (r_half_cnt == c_HALF_LAST);

    always_ff @(posedge sqwv or negedge manual_n) begin
        if (!manual_n) begin
            r_state    <= c_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fsk      <= 1'b0;
            r_trig     <= 1'b0;
`ifdef MCHESTER_REPEAT_EN
            r_copy     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_shift    <= data;
`ifdef MCHESTER_REPEAT_EN
                        r_copy     <= data;
`endif
                        r_bit_cnt  <= c_BIT_LAST;
                        r_half_cnt <= '0;
                        r_fsk      <= data[FRAME_BITS-1];
                        r_trig     <= ~r_trig;
                        r_busy     <= 1'b1;
                        r_state    <= c_HALF1;
                    end
                end
                c_HALF1: begin
                    if (w_half_end) begin
                        r_half_cnt <= '0;
                        r_fsk      <= ~r_shift[FRAME_BITS-1];
                        r_trig     <= ~r_trig;
                        r_state    <= c_HALF2;
                    end else begin
                        r_half_cnt <= r_half_cnt + 1'b1;
                    end
                end
                c_HALF2: begin
                    if (w_half_end) begin
                        r_half_cnt <= '0;
                        // r_bit_cnt holds how many bits remain after the current one
                        if (r_bit_cnt != '0) begin
                            r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            r_fsk     <= r_shift[FRAME_BITS-2];
                            r_trig    <= ~r_trig;
                            r_state   <= c_HALF1;
                        end
`ifdef MCHESTER_REPEAT_EN
                        else if (start) begin
                            r_shift   <= r_copy;
                            r_bit_cnt <= c_BIT_LAST;
                            r_fsk     <= r_copy[FRAME_BITS-1];
                            r_trig    <= ~r_trig;
                            r_done    <= 1'b1;
                            r_state   <= c_HALF1;
                        end
`endif
                        else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_fsk   <= 1'b0;
                            r_state <= c_DONE;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign fsk_in         = r_fsk;
    assign fsk_in_trigger = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_mchester_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_mchester_encode
// Brief    : Scoreboard bench for mchester_encode; a monitor decodes the
//            half-bit stream on each trigger toggle and compares whole frames
//            against words queued by the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mchester_encode;

    localparam int HBC       = 4;
    localparam int FB        = 45;
    localparam int FRAME_CYC = 2 * FB * HBC;

    logic          sqwv     = 1'b0;
    logic          manual_n = 1'b1;
    logic          start    = 1'b0;
    logic [FB-1:0] data     = '0;
    logic          busy;
    logic          done;
    logic          fsk_in;
    logic          fsk_in_trigger;

    mchester_encode #(
        .HALF_BIT_CYCLES(HBC),
        .FRAME_BITS     (FB)
    ) dut (
        .sqwv          (sqwv),
        .manual_n      (manual_n),
        .start         (start),
        .data          (data),
        .busy          (busy),
        .done          (done),
        .fsk_in        (fsk_in),
        .fsk_in_trigger(fsk_in_trigger)
    );

    always #5 sqwv = ~sqwv;

    int            n_vec = 0;
    int            n_err = 0;
    logic [FB-1:0] exp_q[$];

    // ---------------- monitor: Manchester receiver + scoreboard ----------------
    int            cyc       = 0;
    int            first_cyc = 0;
    int            last_tog  = 0;
    logic          prev_trig = 1'b0;
    logic          prev_fsk  = 1'b0;
    logic          tog;
    logic          syms[$];
    logic [FB-1:0] word;
    logic [FB-1:0] want;
    int            comp_bad;
    logic          busy_want;

    always @(negedge sqwv) begin
        cyc++;
        if (!manual_n) begin
            n_vec++;
            if ({busy, done, fsk_in, fsk_in_trigger} != 4'b0000) begin
                n_err++;
                $display("FAIL reset_outputs: got busy/done/fsk/trig=%b required 0000",
                         {busy, done, fsk_in, fsk_in_trigger});
            end
            syms.delete();
            prev_trig = 1'b0;
            prev_fsk  = 1'b0;
        end else begin
            tog = (fsk_in_trigger != prev_trig);
            if (done) begin
                n_vec++;
                if (syms.size() != 2 * FB) begin
                    n_err++;
                    $display("FAIL symbol_count: got %0d required %0d", syms.size(), 2 * FB);
                end else begin
                    comp_bad = 0;
                    for (int i = 0; i < FB; i++) begin
                        word[FB-1-i] = syms[2*i];
                        if (syms[2*i+1] == syms[2*i]) comp_bad++;
                    end
                    n_vec++;
                    if (comp_bad != 0) begin
                        n_err++;
                        $display("FAIL second_half_complement: got %0d bad bits required 0", comp_bad);
                    end
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_done: got frame %h required no frame", word);
                    end else begin
                        want = exp_q.pop_front();
                        if (word !== want) begin
                            n_err++;
                            $display("FAIL frame_word: got %h required %h", word, want);
                        end
                    end
                end
                n_vec++;
                if (cyc - first_cyc != FRAME_CYC) begin
                    n_err++;
                    $display("FAIL frame_length: got %0d required %0d", cyc - first_cyc, FRAME_CYC);
                end
`ifdef MCHESTER_REPEAT_EN
                busy_want = tog;
`else
                busy_want = 1'b0;
`endif
                n_vec++;
                if (busy !== busy_want) begin
                    n_err++;
                    $display("FAIL busy_at_done: got %b required %b", busy, busy_want);
                end
                syms.delete();
            end
            if (tog) begin
                if (syms.size() == 0) begin
                    first_cyc = cyc;
                end else begin
                    n_vec++;
                    if (cyc - last_tog != HBC) begin
                        n_err++;
                        $display("FAIL symbol_period: got %0d required %0d", cyc - last_tog, HBC);
                    end
                end
                last_tog = cyc;
                syms.push_back(fsk_in);
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_in_frame: got %b required 1", busy);
                end
            end else if (!done) begin
                n_vec++;
                if (fsk_in != prev_fsk) begin
                    n_err++;
                    $display("FAIL fsk_without_toggle: got %b required %b", fsk_in, prev_fsk);
                end
            end
            prev_trig = fsk_in_trigger;
            prev_fsk  = fsk_in;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge sqwv);
        #1;
    endtask

    function automatic logic [FB-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[FB-1:0];
    endfunction

    task automatic check(input string name, input logic got, input logic req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < FRAME_CYC + 50; i++) begin
            if (!busy && !done) return;
            tick();
        end
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout: got busy=%b required 0", busy);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < FRAME_CYC + 50; i++) begin
            tick();
            if (done) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL %s_timeout: got no done required done", tag);
    endtask

    // Pulse start for one cycle, then scramble data to show it is not re-read.
    task automatic send(input logic [FB-1:0] d);
        wait_idle();
        start = 1'b1;
        data  = d;
        exp_q.push_back(d);
        tick();
        start = 1'b0;
        data  = rand_word();
        check("busy_after_accept", busy, 1'b1);
    endtask

    logic [FB-1:0] d;

    initial begin
        #2 manual_n = 1'b0;
        repeat (3) tick();
        manual_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check("idle_fsk", fsk_in, 1'b0);
            check("idle_trig", fsk_in_trigger, 1'b0);
        end

        send(45'h0123_456789AB);
        wait_done("frame_a");
        send(45'h1FFF_FFFF_FFFF);
        wait_done("frame_ones");
        send(45'h0);
        wait_done("frame_zeros");

        // start re-raised mid-frame with different data must be ignored
        send(rand_word());
        repeat (99) tick();
        start = 1'b1;
        data  = 45'h155_5555_5555;
        tick();
        start = 1'b0;
        wait_done("no_restart");

        // reset mid-frame discards the partial frame without a done pulse
        send(rand_word());
        repeat (149) tick();
        exp_q.delete();
        manual_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_fsk", fsk_in, 1'b0);
        check("async_rst_trig", fsk_in_trigger, 1'b0);
        repeat (3) tick();
        manual_n = 1'b1;
        tick();
        send(rand_word());
        wait_done("after_reset");

`ifdef MCHESTER_REPEAT_EN
        wait_idle();
        d     = rand_word();
        start = 1'b1;
        data  = d;
        repeat (3) exp_q.push_back(d);
        tick();
        data = rand_word();
        wait_done("repeat_1");
        check("repeat_busy_1", busy, 1'b1);
        wait_done("repeat_2");
        check("repeat_busy_2", busy, 1'b1);
        repeat (100) tick();
        start = 1'b0;
        wait_done("repeat_3");
        check("repeat_end_busy", busy, 1'b0);
`else
        // start held through DONE: re-accept exactly two edges after done
        wait_idle();
        d     = rand_word();
        start = 1'b1;
        data  = d;
        repeat (2) exp_q.push_back(d);
        tick();
        wait_done("held_1");
        tick();
        check("held_gap_idle", busy, 1'b0);
        tick();
        check("held_reaccept", busy, 1'b1);
        start = 1'b0;
        wait_done("held_2");
`endif

        for (int n = 0; n < 5; n++) begin
            wait_idle();
            repeat ($urandom_range(0, 5)) tick();
            send(rand_word());
            wait_done("random");
        end

        repeat (5) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL frames_outstanding: got %0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
